fetch_unit: RTL and testbench

//   Instruction-fetch stage that sits directly upstream of INST_MEM. It owns the program

---
 rtl/riscv_pkg.sv | 12 +
 rtl/fetch_buffer.sv | 72 +++++++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and fetch-state encoding for the fetch stage
package riscv_pkg;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          FETCH_DEPTH  = 2;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_FETCH,
        ST_HALTED
    } fetch_state_e;
endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - 2-entry {pc, instr} FIFO between instruction memory and decode
module fetch_buffer
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [63:0] push_data,
    output logic [1:0]  count,
    output logic [63:0] head_data
);
    logic [63:0] head_q, head_d;
    logic [63:0] tail_q, tail_d;
    logic [1:0]  count_q, count_d;

    // The head register is never cleared on pop or flush, so if_pc/if_instr hold when empty.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d  = push_data;
                        count_d = 2'd1;
                    end else if (count_q == 2'd1) begin
                        tail_d  = push_data;
                        count_d = 2'd2;
                    end
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_d  = tail_q;
                        count_d = 2'd1;
                    end else if (count_q == 2'd1) begin
                        count_d = 2'd0;
                    end
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = push_data;
                    end else begin
                        head_d  = push_data;
                        count_d = 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= {32'h0000_0000, NOP_INSTR};
            tail_q  <= 64'h0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign head_data = head_q;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register, fetch FSM, redirect and misalign flag
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          MEM_BYTES = 32,
    parameter int          DEPTH     = FETCH_DEPTH
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready,
    output logic        misalign_err
);
    localparam logic [31:0] PC_MASK = 32'(MEM_BYTES - 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         misalign_err_q, misalign_err_d;
    logic [1:0]   count;
    logic [63:0]  head_data;
    logic         push, pop;

    assign if_valid = (count != 2'd0);
    assign pop      = if_valid & id_ready;
    assign push     = (state_q == ST_FETCH) & ~halt & ~redirect_valid &
                      ((count < 2'(DEPTH)) | pop);

    // WAIT lasts one cycle so the instruction memory is out of its own reset before the first push.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT:   state_d = ST_FETCH;
            ST_FETCH:  if (halt) state_d = ST_HALTED;
            ST_HALTED: if (!halt) state_d = ST_FETCH;
            default:   state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        pc_d           = pc_q;
        misalign_err_d = misalign_err_q | (redirect_valid & (redirect_pc[1:0] != 2'b00));
        if (redirect_valid) begin
            pc_d = redirect_pc & ~32'd3 & PC_MASK;
        end else if (push) begin
            pc_d = (pc_q + 32'd4) & PC_MASK;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_WAIT;
            pc_q           <= RESET_PC;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    fetch_buffer u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data ({pc_q, imem_instr}),
        .count     (count),
        .head_data (head_data)
    );

    assign imem_pc      = pc_q;
    assign if_pc        = head_data[63:32];
    assign if_instr     = head_data[31:0];
    assign misalign_err = misalign_err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a behavioural instruction memory
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;
    logic        misalign_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] mon_pc, mon_instr;
    logic [31:0] max_pc;

    fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(32), .DEPTH(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .id_ready       (id_ready),
        .misalign_err   (misalign_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        case (pc[4:2])
            3'd0: return 32'h0094_0333;
            3'd1: return 32'h4139_03b3;
            3'd2: return 32'h00f7_68b3;
            3'd3: return 32'h017b_4e33;
            3'd4: return 32'h00d6_7fb3;
            3'd5: return 32'h01ee_8f33;
            3'd6: return 32'h40e5_0eb3;
            default: return 32'h00f7_68b3;
        endcase
    endfunction

    assign imem_instr = mem_word(imem_pc);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Every accepted transfer (not flushed by a concurrent redirect) must match the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && if_valid && id_ready && !redirect_valid) begin
            checks++;
            if (exp_pc_q.size() == 0) begin
                failures++;
                $display("FAIL xfer_unexpected got pc=%h instr=%h with empty scoreboard", if_pc, if_instr);
            end else begin
                mon_pc    = exp_pc_q.pop_front();
                mon_instr = exp_instr_q.pop_front();
                if (if_pc !== mon_pc || if_instr !== mon_instr) begin
                    failures++;
                    $display("FAIL xfer got pc=%h instr=%h required pc=%h instr=%h",
                             if_pc, if_instr, mon_pc, mon_instr);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (imem_pc > max_pc) max_pc = imem_pc;
    endtask

    task automatic expect_at(input logic [31:0] pc, input logic [31:0] instr);
        exp_pc_q.push_back(pc);
        exp_instr_q.push_back(instr);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_pc_q.size() != 0; i++) step();
        check("drain_left", 32'(exp_pc_q.size()), 32'd0);
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_pc    = target;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic seq_from_reset();
        reset_n  = 1'b1;
        id_ready = 1'b1;
        expect_at(32'h0, 32'h0094_0333);
        expect_at(32'h4, 32'h4139_03b3);
        expect_at(32'h8, 32'h00f7_68b3);
        step();
        check("wait_no_valid", 32'(if_valid), 32'd0);
        step();
        check("first_valid", 32'(if_valid), 32'd1);
        check("first_pc", if_pc, 32'h0);
        step();
        check("second_pc", if_pc, 32'h4);
        step();
        check("third_pc", if_pc, 32'h8);
        check("third_instr", if_instr, 32'h00f7_68b3);
        drain(10);
        id_ready = 1'b0;
    endtask

    initial begin
        reset_n        = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        max_pc         = 32'h0;
        step();
        step();
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0000_0013);
        check("rst_imem_pc", imem_pc, 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'd0);

        seq_from_reset();

        // Backpressure: buffer fills behind pc 0 and the PC freezes at 8.
        redirect_to(32'h0);
        for (int i = 0; i < 5; i++) step();
        check("bp_count", 32'(dut.u_buf.count), 32'd2);
        check("bp_imem_pc", imem_pc, 32'h8);
        check("bp_if_pc", if_pc, 32'h0);
        expect_at(32'h0, 32'h0094_0333);
        expect_at(32'h4, 32'h4139_03b3);
        expect_at(32'h8, 32'h00f7_68b3);
        id_ready = 1'b1;
        drain(10);
        id_ready = 1'b0;

        // Wrap: nine fetches from 0 run through 28 and back to 0.
        redirect_to(32'h0);
        for (int i = 0; i < 3; i++) step();
        max_pc = 32'h0;
        expect_at(32'h00, 32'h0094_0333);
        expect_at(32'h04, 32'h4139_03b3);
        expect_at(32'h08, 32'h00f7_68b3);
        expect_at(32'h0c, 32'h017b_4e33);
        expect_at(32'h10, 32'h00d6_7fb3);
        expect_at(32'h14, 32'h01ee_8f33);
        expect_at(32'h18, 32'h40e5_0eb3);
        expect_at(32'h1c, 32'h00f7_68b3);
        expect_at(32'h00, 32'h0094_0333);
        id_ready = 1'b1;
        drain(30);
        id_ready = 1'b0;
        check("wrap_max_imem_pc", max_pc, 32'd28);

        // Redirect to 0x10 while full, with decode ready: the concurrent pop is discarded.
        for (int i = 0; i < 3; i++) step();
        check("full_count", 32'(dut.u_buf.count), 32'd2);
        expect_at(32'h10, 32'h00d6_7fb3);
        id_ready = 1'b1;
        redirect_to(32'h10);
        check("redir_if_valid", 32'(if_valid), 32'd0);
        check("redir_imem_pc", imem_pc, 32'h10);
        step();
        check("redir_if_pc", if_pc, 32'h10);
        check("redir_if_instr", if_instr, 32'h00d6_7fb3);
        drain(5);
        id_ready = 1'b0;

        // Misaligned redirect, then halt while the buffer drains.
        redirect_to(32'h0e);
        check("mis_err", 32'(misalign_err), 32'd1);
        check("mis_imem_pc", imem_pc, 32'h0c);
        step();
        check("mis_if_pc", if_pc, 32'h0c);
        check("mis_if_instr", if_instr, 32'h017b_4e33);
        expect_at(32'h0c, 32'h017b_4e33);
        halt     = 1'b1;
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_imem_pc", imem_pc, 32'h10);
        end
        check("halt_drained", 32'(if_valid), 32'd0);
        check("halt_sb_empty", 32'(exp_pc_q.size()), 32'd0);
        check("mis_sticky", 32'(misalign_err), 32'd1);

        // Redirect while halted: PC moves, no fetch, FSM stays halted.
        redirect_to(32'h08);
        check("hredir_imem_pc", imem_pc, 32'h08);
        step();
        check("hredir_no_push", 32'(if_valid), 32'd0);
        check("hredir_state", 32'(dut.state_q), 32'(ST_HALTED));
        id_ready = 1'b0;
        halt     = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("resume_valid", 32'(if_valid), 32'd1);
        check("resume_if_pc", if_pc, 32'h08);

        // Asynchronous reset between edges.
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_if_valid", 32'(if_valid), 32'd0);
        check("arst_imem_pc", imem_pc, 32'h0);
        check("arst_misalign", 32'(misalign_err), 32'd0);
        step();
        seq_from_reset();

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
